mmio_device_manager: RTL

//  Memory-mapped I/O arbiter between the Antares datapath and NUM_DEV peripheral channels.

---
 rtl/mmio_pkg.sv | 20 ++
 rtl/mmio_channel.sv | 96 +++++++++
 rtl/mmio_device_manager.sv | 79 +++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO device manager: status bit layout, register offsets
// and the per-channel address map.
package mmio_pkg;

    localparam int unsigned ST_BUSY    = 0;
    localparam int unsigned ST_DONE    = 1;
    localparam int unsigned ST_OVR     = 2;
    localparam int unsigned ST_IE      = 3;
    localparam int unsigned ST_W       = 4;

    localparam int unsigned OFF_DATA   = 0;
    localparam int unsigned OFF_STAT   = 4;
    localparam int unsigned DEV_STRIDE = 8;

    // Channels grow downward from the base: channel i sits DEV_STRIDE*i bytes below channel 0.
    function automatic logic [31:0] dev_addr(input logic [31:0] base, input int unsigned i);
        return base - 32'(DEV_STRIDE * i);
    endfunction

endpackage

// File: rtl/mmio_channel.sv
// One device channel: operand register, busy/done/overrun/irq-enable flags and the
// registered one-cycle start pulse.
module mmio_channel
    import mmio_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_data_i,
    input  logic              wr_stat_i,
    input  logic              rd_stat_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              finish_i,
    output logic [DATA_W-1:0] data_o,
    output logic [ST_W-1:0]   stat_o,
    output logic              start_o,
    output logic              irq_o
);

    logic [DATA_W-1:0] data_q, data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ovr_q, ovr_d;
    logic              ie_q, ie_d;
    logic              start_q, start_d;
    logic              accept;

    // A finish arriving in the same cycle frees the channel for the new operand.
    assign accept = wr_data_i & (~busy_q | finish_i);

    always_comb begin
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = done_q;
        ovr_d   = ovr_q;
        ie_d    = ie_q;
        start_d = 1'b0;

        if (wr_stat_i) begin
            ie_d = wdata_i[ST_IE];
        end
        if (rd_stat_i | (wr_stat_i & wdata_i[ST_DONE])) begin
            done_d = 1'b0;
        end
        if (rd_stat_i | (wr_stat_i & wdata_i[ST_OVR])) begin
            ovr_d = 1'b0;
        end

        // Completion set is applied after the clears so it wins over a same-cycle clear.
        if (accept) begin
            data_d  = wdata_i;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            start_d = 1'b1;
        end else if (busy_q & finish_i) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end

        if (wr_data_i & busy_q & ~finish_i) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            ie_q    <= 1'b0;
            start_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            ie_q    <= ie_d;
            start_q <= start_d;
        end
    end

    always_comb begin
        stat_o          = '0;
        stat_o[ST_BUSY] = busy_q;
        stat_o[ST_DONE] = done_q;
        stat_o[ST_OVR]  = ovr_q;
        stat_o[ST_IE]   = ie_q;
    end

    assign data_o  = data_q;
    assign start_o = start_q;
    assign irq_o   = done_q & ie_q;

endmodule

// File: rtl/mmio_device_manager.sv
// MMIO arbiter between the MEM stage and data memory: decodes per-channel DATA/STATUS
// words, diverts hits to the device channels and passes everything else through.
module mmio_device_manager
    import mmio_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned NUM_DEV   = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_FFF8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [ADDR_W-1:0]         address_in,
    input  logic [DATA_W-1:0]         data_in,
    input  logic                      read_in,
    input  logic                      write_in,
    input  logic [DATA_W-1:0]         mem_out_in,
    input  logic [NUM_DEV-1:0]        finish,
    output logic                      read_out,
    output logic                      write_out,
    output logic [DATA_W-1:0]         mem_out_out,
    output logic [NUM_DEV-1:0]        start,
    output logic [NUM_DEV*DATA_W-1:0] dev_data,
    output logic                      irq
);

    logic [NUM_DEV-1:0] hit_data;
    logic [NUM_DEV-1:0] hit_stat;
    logic [NUM_DEV-1:0] ch_irq;
    logic               any_hit;
    logic [DATA_W-1:0]  rd_mux;
    logic [DATA_W-1:0]  ch_data [NUM_DEV];
    logic [ST_W-1:0]    ch_stat [NUM_DEV];

    // Exact word decode; the aligned base makes a misaligned address miss automatically.
    always_comb begin
        hit_data = '0;
        hit_stat = '0;
        for (int unsigned i = 0; i < NUM_DEV; i++) begin
            hit_data[i] = (address_in == ADDR_W'(dev_addr(BASE_ADDR, i) + OFF_DATA));
            hit_stat[i] = (address_in == ADDR_W'(dev_addr(BASE_ADDR, i) + OFF_STAT));
        end
    end

    assign any_hit   = |{hit_data, hit_stat};
    assign read_out  = read_in & ~any_hit;
    assign write_out = write_in & ~any_hit;

    always_comb begin
        rd_mux = '0;
        for (int unsigned i = 0; i < NUM_DEV; i++) begin
            rd_mux = rd_mux | ({DATA_W{hit_data[i]}} & ch_data[i])
                            | ({DATA_W{hit_stat[i]}} & DATA_W'(ch_stat[i]));
        end
    end

    assign mem_out_out = any_hit ? rd_mux : mem_out_in;
    assign irq         = |ch_irq;

    for (genvar g = 0; g < NUM_DEV; g++) begin : g_ch
        mmio_channel #(
            .DATA_W (DATA_W)
        ) u_ch (
            .clock     (clock),
            .reset     (reset),
            .wr_data_i (write_in & hit_data[g]),
            .wr_stat_i (write_in & hit_stat[g]),
            .rd_stat_i (read_in & hit_stat[g]),
            .wdata_i   (data_in),
            .finish_i  (finish[g]),
            .data_o    (ch_data[g]),
            .stat_o    (ch_stat[g]),
            .start_o   (start[g]),
            .irq_o     (ch_irq[g])
        );
        assign dev_data[g*DATA_W +: DATA_W] = ch_data[g];
    end

endmodule
